// File: rtl/count_monitor_pkg.sv
// count_monitor shared types: FSM states, step classes and direction encodings.
package count_mon_pkg;

  // Monitor tracking state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Classification of one sample against the previous one
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/count_monitor_if.sv
// count_monitor bus: observed counter value in, status/statistics out.
// master = environment side (drives count/en/clr), slave = monitor side.
interface count_monitor_if #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8,
  parameter int WRAPW = 16
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] count_in;
  logic             dir;
  logic             dir_valid;
  logic             dir_chg;
  logic             hold;
  logic             wrap_up;
  logic             wrap_dn;
  logic             step_err;
  logic [ERRW-1:0]  err_cnt;
  logic [WRAPW-1:0] wrap_cnt;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;

  modport master (
    output en, clr, count_in,
    input  dir, dir_valid, dir_chg, hold, wrap_up, wrap_dn,
           step_err, err_cnt, wrap_cnt, min_val, max_val
  );

  modport slave (
    input  en, clr, count_in,
    output dir, dir_valid, dir_chg, hold, wrap_up, wrap_dn,
           step_err, err_cnt, wrap_cnt, min_val, max_val
  );
endinterface

// File: rtl/count_monitor_classify.sv
// count_step_classify: combinational step classifier. Compares the new
// sample with the previous one modulo 2^WIDTH and flags wrap-around steps.
module count_step_classify
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_t            step,
  output logic             wrap_up,
  output logic             wrap_dn
);

  logic [WIDTH-1:0] delta;

  // Modular difference; natural truncation gives the mod 2^WIDTH result
  assign delta = count_in - prev;

  // Decode delta into hold / +1 / -1 / illegal; wraps are +1 landing on 0
  // (so prev was max) and -1 landing on max (so prev was 0)
  always_comb begin
    step    = STEP_ERR;
    wrap_up = 1'b0;
    wrap_dn = 1'b0;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == WIDTH'(1)) begin
      step    = STEP_UP;
      wrap_up = (count_in == '0);
    end else if (delta == '1) begin
      step    = STEP_DN;
      wrap_dn = (count_in == '1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: passive observer of an up/down counter bus. Infers direction,
// flags holds, wraps, reversals and illegal steps, and keeps saturating
// statistics. Optional min/max tracking is enabled by COUNT_MONITOR_MINMAX_EN;
// without it min_val/max_val read as 0.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8,
  parameter int WRAPW = 16
) (
  input logic             clk,
  input logic             rst,
  count_monitor_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic             dir_reg, dir_next;
  logic             dir_valid_reg, dir_valid_next;
  logic             dir_chg_reg, dir_chg_next;
  logic             hold_reg, hold_next;
  logic             wrap_up_reg, wrap_up_next;
  logic             wrap_dn_reg, wrap_dn_next;
  logic             step_err_reg, step_err_next;
  logic [ERRW-1:0]  err_cnt_reg, err_cnt_next;
  logic [WRAPW-1:0] wrap_cnt_reg, wrap_cnt_next;

  step_t            step_cls;
  logic             cls_wrap_up;
  logic             cls_wrap_dn;
  logic             step_dir;
  logic             tracking;

  count_step_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .prev     (prev_reg),
    .count_in (bus.count_in),
    .step     (step_cls),
    .wrap_up  (cls_wrap_up),
    .wrap_dn  (cls_wrap_dn)
  );

  assign step_dir = (step_cls == STEP_UP) ? DIR_UP : DIR_DN;
  assign tracking = bus.en && (state_reg == TRACK);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state: en low always parks in IDLE; otherwise IDLE->SYNC->TRACK
  always_comb begin
    state_next = state_reg;
    if (!bus.en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = SYNC;
        SYNC:    state_next = TRACK;
        TRACK:   state_next = TRACK;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output/datapath next values: pulses default low, everything else holds
  always_comb begin
    prev_next      = prev_reg;
    dir_next       = dir_reg;
    dir_valid_next = dir_valid_reg;
    dir_chg_next   = 1'b0;
    hold_next      = 1'b0;
    wrap_up_next   = 1'b0;
    wrap_dn_next   = 1'b0;
    step_err_next  = step_err_reg;
    err_cnt_next   = err_cnt_reg;
    wrap_cnt_next  = wrap_cnt_reg;

    if (bus.en && (state_reg == SYNC)) begin
      prev_next = bus.count_in;
    end

    if (tracking) begin
      // Illegal steps also resync prev, so only the jump itself is flagged
      prev_next = bus.count_in;
      case (step_cls)
        STEP_HOLD: hold_next = 1'b1;
        STEP_UP, STEP_DN: begin
          dir_chg_next   = dir_valid_reg && (step_dir != dir_reg);
          dir_next       = step_dir;
          dir_valid_next = 1'b1;
        end
        default: begin
          step_err_next = 1'b1;
          if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + 1'b1;
        end
      endcase
      wrap_up_next = cls_wrap_up;
      wrap_dn_next = cls_wrap_dn;
      if ((cls_wrap_up || cls_wrap_dn) && (wrap_cnt_reg != '1)) begin
        wrap_cnt_next = wrap_cnt_reg + 1'b1;
      end
    end

    // Clear wins over a coinciding event; tracking state is left alone
    if (bus.clr) begin
      step_err_next = 1'b0;
      err_cnt_next  = '0;
      wrap_cnt_next = '0;
    end
  end

  // Output and tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg      <= '0;
      dir_reg       <= 1'b0;
      dir_valid_reg <= 1'b0;
      dir_chg_reg   <= 1'b0;
      hold_reg      <= 1'b0;
      wrap_up_reg   <= 1'b0;
      wrap_dn_reg   <= 1'b0;
      step_err_reg  <= 1'b0;
      err_cnt_reg   <= '0;
      wrap_cnt_reg  <= '0;
    end else begin
      prev_reg      <= prev_next;
      dir_reg       <= dir_next;
      dir_valid_reg <= dir_valid_next;
      dir_chg_reg   <= dir_chg_next;
      hold_reg      <= hold_next;
      wrap_up_reg   <= wrap_up_next;
      wrap_dn_reg   <= wrap_dn_next;
      step_err_reg  <= step_err_next;
      err_cnt_reg   <= err_cnt_next;
      wrap_cnt_reg  <= wrap_cnt_next;
    end
  end

  assign bus.dir       = dir_reg;
  assign bus.dir_valid = dir_valid_reg;
  assign bus.dir_chg   = dir_chg_reg;
  assign bus.hold      = hold_reg;
  assign bus.wrap_up   = wrap_up_reg;
  assign bus.wrap_dn   = wrap_dn_reg;
  assign bus.step_err  = step_err_reg;
  assign bus.err_cnt   = err_cnt_reg;
  assign bus.wrap_cnt  = wrap_cnt_reg;

`ifdef COUNT_MONITOR_MINMAX_EN
  logic [WIDTH-1:0] min_reg;
  logic [WIDTH-1:0] max_reg;
  logic             armed_reg;

  // Min/max over every sample taken in SYNC/TRACK; an armed tracker reloads
  // both from the next sample (after reset or clr)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_reg   <= '0;
      max_reg   <= '0;
      armed_reg <= 1'b1;
    end else if (bus.clr) begin
      armed_reg <= 1'b1;
    end else if (bus.en && ((state_reg == SYNC) || (state_reg == TRACK))) begin
      if (armed_reg) begin
        min_reg   <= bus.count_in;
        max_reg   <= bus.count_in;
        armed_reg <= 1'b0;
      end else begin
        if (bus.count_in < min_reg) min_reg <= bus.count_in;
        if (bus.count_in > max_reg) max_reg <= bus.count_in;
      end
    end
  end

  assign bus.min_val = min_reg;
  assign bus.max_val = max_reg;
`else
  assign bus.min_val = '0;
  assign bus.max_val = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table walks through sync,
// up/down steps, wraps, reversals, holds, illegal steps, clr and en drop;
// hand sequences cover async reset, err_cnt saturation and min/max.
module tb_count_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  count_monitor_if #(.WIDTH(8), .ERRW(8), .WRAPW(16)) bus ();

  count_monitor #(.WIDTH(8), .ERRW(8), .WRAPW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic [7:0]  cnt;
    logic [30:0] exp;
  } vec_t;

  vec_t vecs[35];

  // Expected status word {dir,dir_valid,dir_chg,hold,wrap_up,wrap_dn,step_err,err_cnt,wrap_cnt}
  function automatic logic [30:0] mk(input logic d, input logic dv, input logic chg,
                                     input logic h, input logic wu, input logic wd,
                                     input logic se, input logic [7:0] ec,
                                     input logic [15:0] wc);
    return {d, dv, chg, h, wu, wd, se, ec, wc};
  endfunction

  function automatic logic [30:0] status();
    return {bus.dir, bus.dir_valid, bus.dir_chg, bus.hold, bus.wrap_up, bus.wrap_dn,
            bus.step_err, bus.err_cnt, bus.wrap_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_min;
    logic [7:0] exp_max;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.count_in = 8'd0;

    // en, clr, count, expected status after the edge
    vecs[0]  = '{1'b1, 1'b0, 8'd0,   mk(0,0,0,0,0,0,0,0,0)};  // IDLE -> SYNC
    vecs[1]  = '{1'b1, 1'b0, 8'd1,   mk(0,0,0,0,0,0,0,0,0)};  // SYNC capture
    vecs[2]  = '{1'b1, 1'b0, 8'd2,   mk(1,1,0,0,0,0,0,0,0)};
    vecs[3]  = '{1'b1, 1'b0, 8'd3,   mk(1,1,0,0,0,0,0,0,0)};
    vecs[4]  = '{1'b0, 1'b0, 8'd253, mk(1,1,0,0,0,0,0,0,0)};  // en drop
    vecs[5]  = '{1'b1, 1'b0, 8'd253, mk(1,1,0,0,0,0,0,0,0)};
    vecs[6]  = '{1'b1, 1'b0, 8'd253, mk(1,1,0,0,0,0,0,0,0)};
    vecs[7]  = '{1'b1, 1'b0, 8'd254, mk(1,1,0,0,0,0,0,0,0)};
    vecs[8]  = '{1'b1, 1'b0, 8'd255, mk(1,1,0,0,0,0,0,0,0)};
    vecs[9]  = '{1'b1, 1'b0, 8'd0,   mk(1,1,0,0,1,0,0,0,1)};  // wrap up
    vecs[10] = '{1'b1, 1'b0, 8'd1,   mk(1,1,0,0,0,0,0,0,1)};
    vecs[11] = '{1'b1, 1'b0, 8'd1,   mk(1,1,0,1,0,0,0,0,1)};  // hold
    vecs[12] = '{1'b1, 1'b0, 8'd0,   mk(0,1,1,0,0,0,0,0,1)};  // reversal
    vecs[13] = '{1'b1, 1'b0, 8'd255, mk(0,1,0,0,0,1,0,0,2)};  // wrap down
    vecs[14] = '{1'b0, 1'b0, 8'd10,  mk(0,1,0,0,0,0,0,0,2)};
    vecs[15] = '{1'b1, 1'b0, 8'd10,  mk(0,1,0,0,0,0,0,0,2)};
    vecs[16] = '{1'b1, 1'b0, 8'd10,  mk(0,1,0,0,0,0,0,0,2)};
    vecs[17] = '{1'b1, 1'b0, 8'd11,  mk(1,1,1,0,0,0,0,0,2)};
    vecs[18] = '{1'b1, 1'b0, 8'd12,  mk(1,1,0,0,0,0,0,0,2)};
    vecs[19] = '{1'b1, 1'b0, 8'd11,  mk(0,1,1,0,0,0,0,0,2)};
    vecs[20] = '{1'b1, 1'b0, 8'd10,  mk(0,1,0,0,0,0,0,0,2)};
    vecs[21] = '{1'b1, 1'b0, 8'd10,  mk(0,1,0,1,0,0,0,0,2)};
    vecs[22] = '{1'b1, 1'b0, 8'd11,  mk(1,1,1,0,0,0,0,0,2)};
    vecs[23] = '{1'b1, 1'b0, 8'd40,  mk(1,1,0,0,0,0,1,1,2)};  // illegal
    vecs[24] = '{1'b1, 1'b0, 8'd41,  mk(1,1,0,0,0,0,1,1,2)};  // resynced
    vecs[25] = '{1'b1, 1'b1, 8'd42,  mk(1,1,0,0,0,0,0,0,0)};  // clr
    vecs[26] = '{1'b1, 1'b0, 8'd43,  mk(1,1,0,0,0,0,0,0,0)};
    vecs[27] = '{1'b1, 1'b1, 8'd100, mk(1,1,0,0,0,0,0,0,0)};  // clr beats error
    vecs[28] = '{1'b1, 1'b0, 8'd101, mk(1,1,0,0,0,0,0,0,0)};
    vecs[29] = '{1'b0, 1'b0, 8'd50,  mk(1,1,0,0,0,0,0,0,0)};
    vecs[30] = '{1'b0, 1'b0, 8'd70,  mk(1,1,0,0,0,0,0,0,0)};
    vecs[31] = '{1'b0, 1'b0, 8'd90,  mk(1,1,0,0,0,0,0,0,0)};
    vecs[32] = '{1'b1, 1'b0, 8'd90,  mk(1,1,0,0,0,0,0,0,0)};
    vecs[33] = '{1'b1, 1'b0, 8'd90,  mk(1,1,0,0,0,0,0,0,0)};
    vecs[34] = '{1'b1, 1'b0, 8'd89,  mk(0,1,1,0,0,0,0,0,0)};

    // Reset state
    tick();
    check("reset_status", 32'(status()), 32'(mk(0,0,0,0,0,0,0,0,0)));
    check("reset_minmax", {16'd0, bus.min_val, bus.max_val}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.en = vecs[i].en;
      bus.clr = vecs[i].clr;
      bus.count_in = vecs[i].cnt;
      tick();
      check($sformatf("vec%0d cnt=%0d", i, vecs[i].cnt), 32'(status()), 32'(vecs[i].exp));
    end
    bus.clr = 1'b0;

    // Async reset mid-TRACK: outputs drop before any further clock edge
    bus.count_in = 8'd90;
    tick();
    check("pre_rst_dir_valid", 32'(bus.dir_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_status", 32'(status()), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;

    // err_cnt saturation: alternate 0/128, every step illegal
    bus.en = 1'b1;
    bus.count_in = 8'd0;
    tick();
    tick();
    for (int i = 1; i <= 300; i++) begin
      bus.count_in = (i % 2 == 1) ? 8'd128 : 8'd0;
      tick();
      if (i == 254) check("err_cnt_254", 32'(bus.err_cnt), 32'd254);
      if (i == 255) check("err_cnt_255", 32'(bus.err_cnt), 32'd255);
    end
    check("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
    check("step_err_sticky", 32'(bus.step_err), 32'd1);
    check("dir_valid_after_errs", 32'(bus.dir_valid), 32'd0);

    // Min/max sweep 30 -> 70 -> 12
    do_reset();
    bus.en = 1'b1;
    bus.count_in = 8'd30;
    tick();
    tick();
    for (int v = 31; v <= 70; v++) begin
      bus.count_in = 8'(v);
      tick();
    end
    for (int v = 69; v >= 12; v--) begin
      bus.count_in = 8'(v);
      tick();
    end
    check("sweep_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("sweep_dir", 32'(bus.dir), 32'd0);
`ifdef COUNT_MONITOR_MINMAX_EN
    exp_min = 8'd12;
    exp_max = 8'd70;
`else
    exp_min = 8'd0;
    exp_max = 8'd0;
`endif
    check("sweep_min", 32'(bus.min_val), 32'(exp_min));
    check("sweep_max", 32'(bus.max_val), 32'(exp_max));

    // clr re-arms: the sample after the clr cycle reloads both
    bus.clr = 1'b1;
    bus.count_in = 8'd13;
    tick();
    bus.clr = 1'b0;
    bus.count_in = 8'd14;
    tick();
`ifdef COUNT_MONITOR_MINMAX_EN
    exp_min = 8'd14;
    exp_max = 8'd14;
`endif
    check("rearm_min", 32'(bus.min_val), 32'(exp_min));
    check("rearm_max", 32'(bus.max_val), 32'(exp_max));
    check("rearm_dir_up", 32'(bus.dir), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
